// File: rtl/ddr_fifo_write_ctrl.sv
// Write-domain pointer controller for the DDR wishbone slave's asynchronous FIFOs.
// Drives RAM write enable/address, exports the Gray write pointer and derives full/level status.
module ddr_fifo_write_ctrl #(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Clear_in,
    input  logic                  Push_in,
    output logic                  PushAccept_out,
    output logic                  WrEn_out,
    output logic [ADDR_WIDTH-1:0] WrAddr_out,
    output logic [ADDR_WIDTH:0]   WrPtrGray_out,
    input  logic [ADDR_WIDTH:0]   RdPtrGray_in,
    output logic                  Full_out,
    output logic                  AlmostFull_out,
    output logic [ADDR_WIDTH:0]   Level_out,
    output logic                  Overflow_out
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH    = PW'(1) << ADDR_WIDTH;
    localparam logic [PW-1:0] MARGIN_V = PW'(ALMOST_FULL_MARGIN);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] gray_q;
    logic [PW-1:0] sync1_q, sync2_q;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          push_acc;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] free_cnt;

    always_comb begin
        push_acc = Push_in & ~full_q & ~Clear_in;
        bin_d    = bin_q + {{ADDR_WIDTH{1'b0}}, push_acc};
        rd_bin   = gray2bin(sync2_q);
        level_d  = bin_d - rd_bin;
        free_cnt = DEPTH - level_d;
        full_d   = (level_d == DEPTH);
        afull_d  = full_d | (free_cnt <= MARGIN_V);
        ovf_d    = ovf_q | (Push_in & full_q);
    end

    // Status is computed from the post-push pointer so it never lags an accepted write.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bin_q   <= '0;
            gray_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (Clear_in) begin
            bin_q   <= '0;
            gray_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= bin2gray(bin_d);
            sync1_q <= RdPtrGray_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign PushAccept_out = push_acc;
    assign WrEn_out       = push_acc;
    assign WrAddr_out     = bin_q[ADDR_WIDTH-1:0];
    assign WrPtrGray_out  = gray_q;
    assign Full_out       = full_q;
    assign AlmostFull_out = afull_q;
    assign Level_out      = level_q;
    assign Overflow_out   = ovf_q;

endmodule

// File: tb/tb_ddr_fifo_write_ctrl.sv
// Scoreboard bench for ddr_fifo_write_ctrl: a count-based occupancy model queues expected
// outputs per cycle and a negedge monitor compares them against the DUT.
module tb_ddr_fifo_write_ctrl;

    localparam int AW     = 4;
    localparam int DEPTH  = 1 << AW;
    localparam int MARGIN = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Clear_in = 1'b0;
    logic          Push_in = 1'b0;
    logic          PushAccept_out, WrEn_out;
    logic [AW-1:0] WrAddr_out;
    logic [AW:0]   WrPtrGray_out;
    logic [AW:0]   RdPtrGray_in = '0;
    logic          Full_out, AlmostFull_out, Overflow_out;
    logic [AW:0]   Level_out;

    ddr_fifo_write_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_MARGIN(MARGIN)) dut (
        .Clk(Clk), .Rst(Rst), .Clear_in(Clear_in), .Push_in(Push_in),
        .PushAccept_out(PushAccept_out), .WrEn_out(WrEn_out), .WrAddr_out(WrAddr_out),
        .WrPtrGray_out(WrPtrGray_out), .RdPtrGray_in(RdPtrGray_in), .Full_out(Full_out),
        .AlmostFull_out(AlmostFull_out), .Level_out(Level_out), .Overflow_out(Overflow_out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit acc;
        int addr;
        int gray;
        bit full;
        bit afull;
        int level;
        bit ovf;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Model state: unbounded write/read counts; occupancy is their plain difference.
    int  wcnt = 0;
    int  rcnt = 0;
    int  s1 = 0, s2 = 0;
    int  m_level = 0;
    bit  m_full = 0, m_afull = 0, m_ovf = 0;
    int  max_level_p5 = 0;

    function automatic int to_gray(input int v);
        int b;
        b = v % (2 * DEPTH);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wcnt = 0; rcnt = 0; s1 = 0; s2 = 0;
        m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    endtask

    // Called just after a rising edge: drive inputs, queue expectations, advance model.
    task automatic step(input bit push, input bit clr);
        exp_t e;
        bit acc;
        Push_in = push;
        Clear_in = clr;
        RdPtrGray_in = (AW+1)'(to_gray(rcnt));
        acc = push && !m_full && !clr;
        e.acc = acc; e.addr = wcnt % DEPTH; e.gray = to_gray(wcnt);
        e.full = m_full; e.afull = m_afull; e.level = m_level; e.ovf = m_ovf;
        q.push_back(e);
        if (clr) begin
            wcnt = 0; s1 = 0; s2 = 0;
            m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        end else begin
            if (push && m_full) m_ovf = 1;
            if (acc) wcnt++;
            m_level = wcnt - s2;
            m_full = (m_level == DEPTH);
            m_afull = m_full || ((DEPTH - m_level) <= MARGIN);
            s2 = s1;
            s1 = rcnt;
        end
        @(posedge Clk);
        #1;
    endtask

    int prev_gray = 0;
    always @(negedge Clk) begin
        if (!Rst && q.size() > 0) begin
            exp_t e;
            int d, ones;
            e = q.pop_front();
            chk("PushAccept", int'(PushAccept_out), int'(e.acc));
            chk("WrEn", int'(WrEn_out), int'(e.acc));
            chk("WrAddr", int'(WrAddr_out), e.addr);
            chk("WrPtrGray", int'(WrPtrGray_out), e.gray);
            chk("Full", int'(Full_out), int'(e.full));
            chk("AlmostFull", int'(AlmostFull_out), int'(e.afull));
            chk("Level", int'(Level_out), e.level);
            chk("Overflow", int'(Overflow_out), int'(e.ovf));
            if (WrPtrGray_out != 0) begin
                d = prev_gray ^ int'(WrPtrGray_out);
                ones = $countones(d);
                chk("GrayOneBitStep", int'(ones <= 1), 1);
            end
            prev_gray = int'(WrPtrGray_out);
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_gray", int'(WrPtrGray_out), 0);
        chk("rst_level", int'(Level_out), 0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
        chk("rel_addr", int'(WrAddr_out), 0);
        chk("rel_full", int'(Full_out), 0);
        chk("rel_afull", int'(AlmostFull_out), 0);
        chk("rel_ovf", int'(Overflow_out), 0);

        // Fill with reads held at 0, then push twice while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
        chk("full_gray_11000", int'(WrPtrGray_out), 5'b11000);
        chk("full_flag", int'(Full_out), 1);
        chk("full_level", int'(Level_out), DEPTH);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("ovf_sticky", int'(Overflow_out), 1);

        // Read side advances to 2; full drops after the synchroniser delay
        rcnt = 2;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("after_read_level", int'(Level_out), DEPTH - 2);
        step(1'b1, 1'b0);

        // Clear, then 40 pushes with the read pointer lagging by 3
        step(1'b0, 1'b1);
        rcnt = 0;
        for (int i = 0; i < 40; i++) begin
            rcnt = (wcnt > 3) ? wcnt - 3 : 0;
            step(1'b1, 1'b0);
            if (int'(Level_out) > max_level_p5) max_level_p5 = int'(Level_out);
        end
        chk("lag_max_level_le6", int'(max_level_p5 <= 6), 1);
        chk("lag_wrapped_cnt", wcnt, 40);

        // Random pushes and read advances
        for (int i = 0; i < 300; i++) begin
            if (rcnt < wcnt && ($urandom % 3) == 0) rcnt++;
            step(($urandom % 4) != 0, 1'b0);
        end

        // Clear with simultaneous push at level 5
        step(1'b0, 1'b1);
        rcnt = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("pre_clear_level", int'(Level_out), 5);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        #1;
        Rst = 1'b1;
        #1;
        chk("arst_addr", int'(WrAddr_out), 0);
        chk("arst_gray", int'(WrPtrGray_out), 0);
        chk("arst_level", int'(Level_out), 0);
        chk("arst_full", int'(Full_out), 0);
        chk("arst_afull", int'(AlmostFull_out), 0);
        chk("arst_ovf", int'(Overflow_out), 0);
        Push_in = 1'b0;
        @(posedge Clk);
        #1;
        q.delete();
        Rst = 1'b0;
        model_reset();
        prev_gray = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        @(negedge Clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_fifo_write_ctrl.md
Name: ddr_fifo_write_ctrl

Overview:
Write-side pointer controller for the DDR wishbone slave's asynchronous FIFOs, running in the write clock domain.
- Accepts push requests and drives the write address and write enable into the dual-port RAM.
- Keeps the binary and Gray-coded write pointers.
- Synchronises the read-domain Gray pointer and generates full, almost-full, fill level and overflow status.
- The read side is a mirror block in the other clock domain; it exchanges Gray pointers with this block.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits wide.
ALMOST_FULL_MARGIN, 2, AlmostFull_out asserts when free entries <= this value; legal range 1..2^ADDR_WIDTH-1.

Ports:
Clk  input  1  write-domain clock; all flops are rising-edge.
Rst  input  1  reset, asynchronous, active-high.
Clear_in  input  1  synchronous clear of pointers, synchronisers and status; must be asserted together with the read-side clear.
Push_in  input  1  write request; the caller's data is valid in the same cycle.
PushAccept_out  output  1  combinational; Push_in & ~Full_out & ~Clear_in.
WrEn_out  output  1  RAM write enable; equal to PushAccept_out.
WrAddr_out  output  ADDR_WIDTH  RAM write address; low bits of the registered binary write pointer.
WrPtrGray_out  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
RdPtrGray_in  input  ADDR_WIDTH+1  read-domain Gray pointer; asynchronous to Clk.
Full_out  output  1  registered full flag.
AlmostFull_out  output  1  registered almost-full flag.
Level_out  output  ADDR_WIDTH+1  registered, pessimistic occupancy, range 0..2^ADDR_WIDTH.
Overflow_out  output  1  sticky; set by a push attempted while Full_out=1.

Behaviour:
- Reset (async, Rst=1):
  - binary pointer, WrPtrGray_out and both synchroniser stages = 0.
  - Full_out, AlmostFull_out, Level_out, Overflow_out = 0.
- Clear_in=1 at a clock edge: same values as reset. Clear has priority over Push_in; no write occurs (PushAccept_out=0 while Clear_in=1).
- Read-pointer synchroniser: two flop stages, sync1 <= RdPtrGray_in, sync2 <= sync1. Only sync2 is used by the logic.
- Synchronised read pointer conversion: rd_bin[ADDR_WIDTH] = sync2[ADDR_WIDTH]; rd_bin[i] = rd_bin[i+1] ^ sync2[i].
- Pointer update, per cycle:
  - next_bin = bin + PushAccept_out, modulo 2^(ADDR_WIDTH+1).
  - Registered: bin <= next_bin; WrPtrGray_out <= next_bin ^ (next_bin >> 1).
  - Only one Gray bit changes per increment.
  - Wrap from all-ones to 0 is normal operation.
- Status, registered from next_bin and the current sync2:
  - next_level = next_bin - rd_bin, modulo 2^(ADDR_WIDTH+1).
  - Level_out <= next_level.
  - Full_out <= (next_level == 2^ADDR_WIDTH); equivalently, next Gray pointer equals sync2 with its top two bits inverted.
  - AlmostFull_out <= (2^ADDR_WIDTH - next_level) <= ALMOST_FULL_MARGIN; it is also 1 whenever Full_out is 1.
- Latency:
  - A push accepted in cycle N appears in Full_out, Level_out and WrPtrGray_out in cycle N+1.
  - A read-pointer change at the input reaches sync2 after 2 edges and the status after 3 edges. Full deassertion is therefore delayed, which is safe (pessimistic).
- Full boundary:
  - With Full_out=1, a push is refused (WrEn_out=0) and the pointer holds.
  - Overflow_out <= 1 and stays set until Rst or Clear_in.
- Simultaneous push and read-pointer advance: both are applied; the level stays unchanged once the read advance reaches sync2.
- No decrement or read logic lives in this block; the empty side is owned by the read controller.

Test Plan:
1. Reset, then Rst released with ADDR_WIDTH=4 -> WrAddr_out=0, WrPtrGray_out=0, Full_out=0, AlmostFull_out=0, Level_out=0, Overflow_out=0.
2. 16 consecutive pushes with RdPtrGray_in=0 -> WrAddr_out steps 0..15; WrPtrGray_out steps 00001, 00011, 00010, ... and ends at 11000. Level_out=14 and AlmostFull_out=1 one cycle after the 14th push. Full_out=1 and Level_out=16 one cycle after the 16th push.
3. While full, Push_in=1 for 2 cycles -> WrEn_out=0, pointer holds at binary 16, Overflow_out=1 and stays 1.
4. Full FIFO, then RdPtrGray_in changed to 00011 (binary 2) -> Full_out=0 and Level_out=14 exactly 3 edges later; the next push is accepted at WrAddr_out=0.
5. 40 pushes with RdPtrGray_in tracking the write pointer, lagging by 3 -> pointer wraps 31->0 with Gray going 10000->00000. Full_out is never set and Level_out never exceeds 6.
6. Clear_in and Push_in asserted together with Level_out=5 -> no write; every output returns to its reset value on the next edge. Async Rst asserted mid-burst -> outputs go to reset values immediately, without waiting for a clock edge.
